// File: rtl/tic_pkg.sv
// Shared constants and types for the tic-tac-toe CPU opponent.
// Cell encodings, FSM states, the winning-line table and fallback move order.
package tic_pkg;

   localparam logic [1:0] CELL_EMPTY  = 2'b00;
   localparam logic [1:0] CELL_PLAYER = 2'b01;
   localparam logic [1:0] CELL_CPU    = 2'b10;

   localparam logic [3:0] TIC_CENTRE     = 4'd4;
   localparam logic [3:0] TIC_NO_MOVE    = 4'hF;
   localparam logic [3:0] TIC_FULL_TURNS = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_PICK  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_HOLD  = 3'd4
   } tic_state_e;

   typedef logic [8:0][1:0] tic_board_t;

   // Rows, then columns, then the two diagonals.
   localparam logic [3:0] TIC_LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Element [0] is tried first.
   localparam logic [3:0][3:0] TIC_CORNERS = {4'd8, 4'd6, 4'd2, 4'd0};
   localparam logic [3:0][3:0] TIC_EDGES   = {4'd7, 4'd5, 4'd3, 4'd1};

   // Returns {found, index} of the first empty cell in the given order.
   function automatic logic [4:0] first_free(input tic_board_t b, input logic [3:0][3:0] order);
      logic [4:0] res;
      res = {1'b0, 4'd0};
      for (int i = 3; i >= 0; i--) begin
         if (b[order[i]] == CELL_EMPTY) begin
            res = {1'b1, order[i]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tic_line_eval.sv
// Combinational judgement of one three-cell line: CPU win, player threat, empty slot.
// The block output exists only when TIC_CPU_BLOCK_EN is defined.
module tic_line_eval
   import tic_pkg::*;
(
   input  logic [1:0] cell_a,
   input  logic [1:0] cell_b,
   input  logic [1:0] cell_c,
   output logic       win,
`ifdef TIC_CPU_BLOCK_EN
   output logic       block,
`endif
   output logic [1:0] empty_idx
);

   function automatic logic [1:0] count_eq(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c, input logic [1:0] val);
      return {1'b0, a == val} + {1'b0, b == val} + {1'b0, c == val};
   endfunction

   logic [1:0] n_cpu_s;
   logic [1:0] n_empty_s;

   assign n_cpu_s   = count_eq(cell_a, cell_b, cell_c, CELL_CPU);
   assign n_empty_s = count_eq(cell_a, cell_b, cell_c, CELL_EMPTY);
   assign win       = (n_cpu_s == 2'd2) && (n_empty_s == 2'd1);

`ifdef TIC_CPU_BLOCK_EN
   logic [1:0] n_player_s;
   assign n_player_s = count_eq(cell_a, cell_b, cell_c, CELL_PLAYER);
   assign block      = (n_player_s == 2'd2) && (n_empty_s == 2'd1);
`endif

   // Position of the first empty cell within the line.
   always_comb begin
      empty_idx = 2'd0;
      if (cell_a == CELL_EMPTY) begin
         empty_idx = 2'd0;
      end else if (cell_b == CELL_EMPTY) begin
         empty_idx = 2'd1;
      end else if (cell_c == CELL_EMPTY) begin
         empty_idx = 2'd2;
      end else begin
         empty_idx = 2'd0;
      end
   end

endmodule

// File: rtl/tic_cpu_mover.sv
// CPU opponent: snapshots the board on the player's turn, scans lines, issues one move.
// Define TIC_CPU_BLOCK_EN to also block two-in-a-row player threats.
module tic_cpu_mover
   import tic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [1:0] board1,
   input  logic [1:0] board2,
   input  logic [1:0] board3,
   input  logic [1:0] board4,
   input  logic [1:0] board5,
   input  logic [1:0] board6,
   input  logic [1:0] board7,
   input  logic [1:0] board8,
   input  logic [1:0] board9,
   input  logic       player_done,
   input  logic       cpu_done,
   input  logic [3:0] turns,
   output logic [8:0] select_cpu,
   output logic       enable_cpu,
   output logic       busy,
   output logic [3:0] cpu_move,
   output logic       no_move
);

   tic_state_e state_r, state_nx_s;
   tic_board_t snap_r, live_s;
   logic [2:0] line_r;
   logic       win_found_r;
   logic [3:0] win_idx_r;
`ifdef TIC_CPU_BLOCK_EN
   logic       block_found_r;
   logic [3:0] block_idx_r;
   logic       block_s;
`endif
   logic [8:0] select_r;
   logic       enable_r, busy_r, no_move_r;
   logic [3:0] cpu_move_r;

   logic       reset_s, trig_s, full_s;
   logic       win_s;
   logic [1:0] empty_idx_s;
   logic [3:0] line_cell_s;
   logic [4:0] corner_s, edge_s;
   logic       pick_found_s;
   logic [3:0] pick_idx_s;
   logic       snap_load_s, issue_set_s, issue_done_s, no_move_s;

   assign reset_s = rst | clr;
   assign trig_s  = player_done & ~cpu_done;
   assign full_s  = turns >= TIC_FULL_TURNS;
   assign live_s  = {board9, board8, board7, board6, board5, board4, board3, board2, board1};

   tic_line_eval u_line_eval (
      .cell_a    (snap_r[TIC_LINES[line_r][0]]),
      .cell_b    (snap_r[TIC_LINES[line_r][1]]),
      .cell_c    (snap_r[TIC_LINES[line_r][2]]),
      .win       (win_s),
`ifdef TIC_CPU_BLOCK_EN
      .block     (block_s),
`endif
      .empty_idx (empty_idx_s)
   );

   assign line_cell_s = TIC_LINES[line_r][empty_idx_s];

   // Move priority over the finished scan: win, block, centre, corners, edges.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = 4'd0;
      corner_s     = first_free(snap_r, TIC_CORNERS);
      edge_s       = first_free(snap_r, TIC_EDGES);
      if (win_found_r) begin
         pick_found_s = 1'b1;
         pick_idx_s   = win_idx_r;
`ifdef TIC_CPU_BLOCK_EN
      end else if (block_found_r) begin
         pick_found_s = 1'b1;
         pick_idx_s   = block_idx_r;
`endif
      end else if (snap_r[TIC_CENTRE] == CELL_EMPTY) begin
         pick_found_s = 1'b1;
         pick_idx_s   = TIC_CENTRE;
      end else if (corner_s[4]) begin
         pick_found_s = 1'b1;
         pick_idx_s   = corner_s[3:0];
      end else if (edge_s[4]) begin
         pick_found_s = 1'b1;
         pick_idx_s   = edge_s[3:0];
      end else begin
         pick_found_s = 1'b0;
         pick_idx_s   = 4'd0;
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nx_s   = state_r;
      snap_load_s  = 1'b0;
      issue_set_s  = 1'b0;
      issue_done_s = 1'b0;
      no_move_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (trig_s && full_s) begin
               no_move_s  = 1'b1;
               state_nx_s = ST_HOLD;
            end else if (trig_s) begin
               snap_load_s = 1'b1;
               state_nx_s  = ST_SCAN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (line_r == 3'd7) begin
               state_nx_s = ST_PICK;
            end else begin
               state_nx_s = ST_SCAN;
            end
         end
         ST_PICK: begin
            if (pick_found_s) begin
               issue_set_s = 1'b1;
               state_nx_s  = ST_ISSUE;
            end else begin
               no_move_s  = 1'b1;
               state_nx_s = ST_HOLD;
            end
         end
         ST_ISSUE: begin
            if (cpu_done) begin
               issue_done_s = 1'b1;
               state_nx_s   = ST_IDLE;
            end else begin
               state_nx_s = ST_ISSUE;
            end
         end
         // Wait out the stale handshake so the same trigger is not taken twice.
         ST_HOLD: begin
            if (!trig_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset_s) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Snapshot, scan candidates and registered outputs.
   always_ff @(posedge clk) begin
      if (reset_s) begin
         snap_r        <= 18'd0;
         line_r        <= 3'd0;
         win_found_r   <= 1'b0;
         win_idx_r     <= 4'd0;
`ifdef TIC_CPU_BLOCK_EN
         block_found_r <= 1'b0;
         block_idx_r   <= 4'd0;
`endif
         select_r      <= 9'd0;
         enable_r      <= 1'b0;
         busy_r        <= 1'b0;
         no_move_r     <= 1'b0;
         cpu_move_r    <= TIC_NO_MOVE;
      end else begin
         no_move_r <= no_move_s;
         busy_r    <= (state_nx_s != ST_IDLE);
         if (snap_load_s) begin
            snap_r        <= live_s;
            line_r        <= 3'd0;
            win_found_r   <= 1'b0;
            win_idx_r     <= 4'd0;
`ifdef TIC_CPU_BLOCK_EN
            block_found_r <= 1'b0;
            block_idx_r   <= 4'd0;
`endif
         end else if (state_r == ST_SCAN) begin
            line_r <= line_r + 3'd1;
            if (win_s && !win_found_r) begin
               win_found_r <= 1'b1;
               win_idx_r   <= line_cell_s;
            end
`ifdef TIC_CPU_BLOCK_EN
            if (block_s && !block_found_r) begin
               block_found_r <= 1'b1;
               block_idx_r   <= line_cell_s;
            end
`endif
         end
         if (issue_set_s) begin
            select_r   <= 9'd1 << pick_idx_s;
            enable_r   <= 1'b1;
            cpu_move_r <= pick_idx_s;
         end else if (issue_done_s) begin
            select_r <= 9'd0;
            enable_r <= 1'b0;
         end
      end
   end

   assign select_cpu = select_r;
   assign enable_cpu = enable_r;
   assign busy       = busy_r;
   assign no_move    = no_move_r;
   assign cpu_move   = cpu_move_r;

endmodule

// File: tb/tb_tic_cpu_mover.sv
// Randomized bench for tic_cpu_mover against a direct move-rule reference model.
module tb_tic_cpu_mover;

`ifdef TIC_CPU_BLOCK_EN
   localparam bit BLOCK_EN = 1'b1;
`else
   localparam bit BLOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, clr, player_done, cpu_done;
   logic [1:0] bd [9];
   logic [3:0] turns;
   logic [8:0] select_cpu;
   logic       enable_cpu, busy, no_move;
   logic [3:0] cpu_move;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tic_cpu_mover dut (
      .clk(clk), .rst(rst), .clr(clr),
      .board1(bd[0]), .board2(bd[1]), .board3(bd[2]),
      .board4(bd[3]), .board5(bd[4]), .board6(bd[5]),
      .board7(bd[6]), .board8(bd[7]), .board9(bd[8]),
      .player_done(player_done), .cpu_done(cpu_done), .turns(turns),
      .select_cpu(select_cpu), .enable_cpu(enable_cpu), .busy(busy),
      .cpu_move(cpu_move), .no_move(no_move)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first winning line, then first threat line, centre, corners, edges; -1 if none.
   function automatic int ref_move(input logic [1:0] b [9]);
      int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      int corners [4] = '{0, 2, 6, 8};
      int edges [4]   = '{1, 3, 5, 7};
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0 || BLOCK_EN) begin
            for (int l = 0; l < 8; l++) begin
               int nown = 0, nemp = 0, hole = -1;
               for (int k = 0; k < 3; k++) begin
                  int c = lines[l][k];
                  if (b[c] == 2'b00) begin nemp++; if (hole < 0) hole = c; end
                  else if (b[c] == ((pass == 0) ? 2'b10 : 2'b01)) nown++;
               end
               if (nown == 2 && nemp == 1) return hole;
            end
         end
      end
      if (b[4] == 2'b00) return 4;
      foreach (corners[i]) if (b[corners[i]] == 2'b00) return corners[i];
      foreach (edges[i]) if (b[edges[i]] == 2'b00) return edges[i];
      return -1;
   endfunction

   task automatic clear_board();
      foreach (bd[i]) bd[i] = 2'b00;
   endtask

   // One full turn; forced >= 0 overrides the model with a hand-derived cell.
   task automatic run_move(input int accept_wait, input bit scramble, input int forced);
      logic [1:0] snap [9];
      int exp;
      snap = bd;
      exp  = (forced >= 0) ? forced : ref_move(snap);
      player_done = 1'b1;
      cpu_done    = 1'b0;
      tick();
      if (turns >= 4'd5) begin
         chk("full_no_move", no_move, 1);
         chk("full_enable", enable_cpu, 0);
         chk("full_busy", busy, 1);
         tick();
         chk("full_no_move_drop", no_move, 0);
         tick();
         chk("hold_busy", busy, 1);
         chk("hold_no_retrig", enable_cpu, 0);
         player_done = 1'b0;
         tick();
         chk("hold_exit", busy, 0);
         return;
      end
      chk("scan_busy", busy, 1);
      chk("scan_no_move", no_move, 0);
      if (scramble) foreach (bd[i]) bd[i] = 2'($urandom_range(0, 2));
      repeat (8) tick();
      chk("pre_enable", enable_cpu, 0);
      tick();
      if (exp < 0) begin
         chk("pick_no_move", no_move, 1);
         chk("pick_enable", enable_cpu, 0);
         tick();
         chk("pick_no_move_drop", no_move, 0);
         chk("pick_hold_busy", busy, 1);
         player_done = 1'b0;
         tick();
         chk("pick_hold_exit", busy, 0);
         return;
      end
      chk("enable_rise", enable_cpu, 1);
      chk("select", select_cpu, 32'd1 << exp);
      chk("cpu_move", cpu_move, exp);
      for (int i = 0; i < accept_wait; i++) begin
         tick();
         chk("issue_select", select_cpu, 32'd1 << exp);
         chk("issue_busy", busy, 1);
      end
      cpu_done = 1'b1;
      tick();
      chk("accept_enable", enable_cpu, 0);
      chk("accept_select", select_cpu, 0);
      chk("accept_move", cpu_move, exp);
      chk("accept_busy", busy, 0);
      player_done = 1'b0;
      cpu_done    = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_select"}, select_cpu, 0);
      chk({tag, "_enable"}, enable_cpu, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_no_move"}, no_move, 0);
      chk({tag, "_cpu_move"}, cpu_move, 4'hF);
   endtask

   // Abort a turn with clr after `cycles` edges past the trigger.
   task automatic clr_abort(input int cycles, input string tag);
      player_done = 1'b1;
      cpu_done    = 1'b0;
      repeat (cycles) tick();
      clr         = 1'b1;
      player_done = 1'b0;
      tick();
      clr = 1'b0;
      check_reset_values(tag);
      tick();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; player_done = 1'b0; cpu_done = 1'b0; turns = 4'd0;
      clear_board();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_values("reset");

      // Player opened in a corner: centre, with a long ISSUE wait.
      clear_board(); bd[0] = 2'b01; turns = 4'd1;
      run_move(20, 1'b0, 4);
      // CPU 0,1 and player 3,4: win at 2 beats block at 5.
      clear_board(); bd[0] = 2'b10; bd[1] = 2'b10; bd[3] = 2'b01; bd[4] = 2'b01; turns = 4'd2;
      run_move(1, 1'b1, 2);
      // Player 1,4: block at 7, otherwise first corner 0.
      clear_board(); bd[1] = 2'b01; bd[4] = 2'b01; turns = 4'd2;
      run_move(1, 1'b0, BLOCK_EN ? 7 : 0);
      // Board full by turn count.
      clear_board(); turns = 4'd5;
      run_move(0, 1'b0, -1);

      // clr during SCAN and during ISSUE.
      clear_board(); bd[4] = 2'b01; turns = 4'd1;
      clr_abort(4, "clr_scan");
      clr_abort(13, "clr_issue");

      for (int n = 0; n < 48; n++) begin
         int np = 0;
         foreach (bd[i]) begin
            int r = $urandom_range(0, 4);
            if (n % 12 == 11) bd[i] = (r < 2) ? 2'b01 : 2'b10;
            else bd[i] = (r < 3) ? 2'b00 : ((r == 3) ? 2'b01 : 2'b10);
            if (bd[i] == 2'b01) np++;
         end
         turns = (n % 12 == 11) ? 4'd4 : 4'(np);
         run_move($urandom_range(1, 4), n[0], -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
